// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned InstWidth = 32;
  localparam int unsigned IdxWidth  = 8;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_unit_icache_dm.sv
// Direct-mapped instruction cache: combinational lookup, one write port,
// valid bits cleared asynchronously by reset.
module icache_dm
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned INST_W = InstWidth,
  parameter int unsigned IDX_W  = IdxWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:2] rd_addr,
  output logic              hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:2] wr_addr,
  input  logic [INST_W-1:0] wr_data
);

  localparam int unsigned Depth = 1 << IDX_W;
  localparam int unsigned TagW  = ADDR_W - IDX_W - 2;

  logic [Depth-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [Depth];
  logic [INST_W-1:0] data_q [Depth];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TagW-1:0]  rd_tag, wr_tag;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[ADDR_W-1:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[ADDR_W-1:IDX_W+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= True;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: I-cache lookup, MC miss handshake, predictor hookup,
// roll-back cancellation of in-flight misses. Optional counters: IF_PERF_CNT_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned INST_W = InstWidth,
  parameter int unsigned IDX_W  = IdxWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              MC_input_valid,
  input  logic [INST_W-1:0] MC_inst,
  output logic              MC_need_fetch,
  output logic [ADDR_W-1:0] MC_fetch_pc,
  input  logic              PDC_need_jump,
  input  logic [ADDR_W-1:0] PDC_predicted_imm,
  output logic [INST_W-1:0] PDC_inst,
  output logic [ADDR_W-1:0] PDC_inst_pc,
  input  logic              IQ_is_full,
  output logic              IQ_output_valid,
  output logic [INST_W-1:0] IQ_inst,
  output logic [ADDR_W-1:0] IQ_inst_pc,
  output logic              IQ_predicted_to_jump,
  output logic [ADDR_W-1:0] IQ_predicted_pc,
  input  logic              ROB_roll_back_flag,
  input  logic [ADDR_W-1:0] ROB_roll_back_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  if_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] next_pc;
  logic              hit;
  logic [INST_W-1:0] cache_data;
  logic              fill;

  logic              need_d, ov_d, pj_d;
  logic [ADDR_W-1:0] mpc_d, ipc_d, ppc_d;
  logic [INST_W-1:0] inst_d;

  icache_dm #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .IDX_W (IDX_W)
  ) u_icache (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(fetch_pc_q[ADDR_W-1:2]),
    .hit    (hit),
    .rd_data(cache_data),
    .wr_en  (fill && rdy),
    .wr_addr(MC_fetch_pc[ADDR_W-1:2]),
    .wr_data(MC_inst)
  );

  assign PDC_inst    = hit ? cache_data : MC_inst;
  assign PDC_inst_pc = fetch_pc_q;
  assign next_pc     = PDC_need_jump ? fetch_pc_q + PDC_predicted_imm : fetch_pc_q + ADDR_W'(4);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    need_d     = MC_need_fetch;
    mpc_d      = MC_fetch_pc;
    ov_d       = False;
    inst_d     = IQ_inst;
    ipc_d      = IQ_inst_pc;
    pj_d       = IQ_predicted_to_jump;
    ppc_d      = IQ_predicted_pc;
    fill       = False;
    case (state_q)
      IF_IDLE: begin
        if (ROB_roll_back_flag) begin
          fetch_pc_d = ROB_roll_back_pc;
        end else if (!IQ_is_full) begin
          if (hit) begin
            ov_d       = True;
            inst_d     = PDC_inst;
            ipc_d      = fetch_pc_q;
            pj_d       = PDC_need_jump;
            ppc_d      = next_pc;
            fetch_pc_d = next_pc;
          end else begin
            need_d  = True;
            mpc_d   = fetch_pc_q;
            state_d = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        // A roll back coinciding with the response still fills, but never delivers.
        if (MC_input_valid) begin
          fill    = True;
          need_d  = False;
          state_d = IF_IDLE;
          if (!ROB_roll_back_flag && !IQ_is_full) begin
            ov_d       = True;
            inst_d     = PDC_inst;
            ipc_d      = fetch_pc_q;
            pj_d       = PDC_need_jump;
            ppc_d      = next_pc;
            fetch_pc_d = next_pc;
          end
        end else if (ROB_roll_back_flag) begin
          state_d = IF_DROP;
        end
        if (ROB_roll_back_flag) fetch_pc_d = ROB_roll_back_pc;
      end
      IF_DROP: begin
        if (MC_input_valid) begin
          fill    = True;
          need_d  = False;
          state_d = IF_IDLE;
        end
        if (ROB_roll_back_flag) fetch_pc_d = ROB_roll_back_pc;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= IF_IDLE;
      fetch_pc_q           <= '0;
      MC_need_fetch        <= False;
      MC_fetch_pc          <= '0;
      IQ_output_valid      <= False;
      IQ_inst              <= '0;
      IQ_inst_pc           <= '0;
      IQ_predicted_to_jump <= False;
      IQ_predicted_pc      <= '0;
    end else if (rdy) begin
      state_q              <= state_d;
      fetch_pc_q           <= fetch_pc_d;
      MC_need_fetch        <= need_d;
      MC_fetch_pc          <= mpc_d;
      IQ_output_valid      <= ov_d;
      IQ_inst              <= inst_d;
      IQ_inst_pc           <= ipc_d;
      IQ_predicted_to_jump <= pj_d;
      IQ_predicted_pc      <= ppc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic hit_evt, miss_evt;
  assign hit_evt  = (state_q == IF_IDLE) && !ROB_roll_back_flag && !IQ_is_full && hit;
  assign miss_evt = (state_q == IF_IDLE) && !ROB_roll_back_flag && !IQ_is_full && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (rdy) begin
      if (hit_evt)  perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (miss_evt) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized self-checking bench for inst_fetch_unit against a transaction-level
// fetch model (word-addressed cache table, pending-request flags).
module tb_inst_fetch_unit;

  localparam int unsigned AW  = 32;
  localparam int unsigned IW  = 32;
  localparam int unsigned IXW = 4;
  localparam int unsigned NENT = 1 << IXW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b0;
  logic          MC_input_valid = 1'b0;
  logic [IW-1:0] MC_inst = '0;
  logic          MC_need_fetch;
  logic [AW-1:0] MC_fetch_pc;
  logic          PDC_need_jump = 1'b0;
  logic [AW-1:0] PDC_predicted_imm = '0;
  logic [IW-1:0] PDC_inst;
  logic [AW-1:0] PDC_inst_pc;
  logic          IQ_is_full = 1'b0;
  logic          IQ_output_valid;
  logic [IW-1:0] IQ_inst;
  logic [AW-1:0] IQ_inst_pc;
  logic          IQ_predicted_to_jump;
  logic [AW-1:0] IQ_predicted_pc;
  logic          ROB_roll_back_flag = 1'b0;
  logic [AW-1:0] ROB_roll_back_pc = '0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .IDX_W(IXW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .MC_input_valid(MC_input_valid), .MC_inst(MC_inst),
    .MC_need_fetch(MC_need_fetch), .MC_fetch_pc(MC_fetch_pc),
    .PDC_need_jump(PDC_need_jump), .PDC_predicted_imm(PDC_predicted_imm),
    .PDC_inst(PDC_inst), .PDC_inst_pc(PDC_inst_pc),
    .IQ_is_full(IQ_is_full), .IQ_output_valid(IQ_output_valid),
    .IQ_inst(IQ_inst), .IQ_inst_pc(IQ_inst_pc),
    .IQ_predicted_to_jump(IQ_predicted_to_jump), .IQ_predicted_pc(IQ_predicted_pc),
    .ROB_roll_back_flag(ROB_roll_back_flag), .ROB_roll_back_pc(ROB_roll_back_pc)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_wait, m_drop;
  logic [31:0]   m_pc, m_req;
  bit            m_ov, m_pj;
  logic [31:0]   m_inst, m_ipc, m_ppc;
  bit            c_valid [NENT];
  logic [31:0]   c_addr  [NENT];
  logic [31:0]   c_data  [NENT];
  int            mc_delay;
  int            fixed_delay = -1;
  int unsigned   obs_need, obs_pulse;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h0100_0193) ^ 32'h0000_0013;
  endfunction

  function automatic int unsigned slot(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit cached(input logic [31:0] pc);
    return c_valid[slot(pc)] && (c_addr[slot(pc)][31:2] == pc[31:2]);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_drop = 0; m_pc = '0; m_req = '0;
    m_ov = 0; m_pj = 0; m_inst = '0; m_ipc = '0; m_ppc = '0;
    for (int i = 0; i < int'(NENT); i++) c_valid[i] = 0;
    mc_delay = 0;
  endtask

  task automatic check_outputs();
    if (MC_need_fetch === 1'b1) obs_need++;
    if (IQ_output_valid === 1'b1) obs_pulse++;
    check("iq_valid", 32'(IQ_output_valid), 32'(m_ov));
    check("iq_inst", IQ_inst, m_inst);
    check("iq_pc", IQ_inst_pc, m_ipc);
    check("iq_pjump", 32'(IQ_predicted_to_jump), 32'(m_pj));
    check("iq_ppc", IQ_predicted_pc, m_ppc);
    check("mc_need", 32'(MC_need_fetch), 32'(m_wait));
    check("mc_pc", MC_fetch_pc, m_req);
  endtask

  task automatic deliver(input logic [31:0] inst, input bit j, input logic [31:0] np);
    m_ov = 1; m_inst = inst; m_ipc = m_pc; m_pj = j; m_ppc = np; m_pc = np;
  endtask

  // One clock cycle: check, drive inputs, check comb outputs, advance the model.
  task automatic step(input bit r, input bit f, input bit j, input logic [31:0] imm,
                      input bit rb, input logic [31:0] rbpc);
    bit mcv, h;
    logic [31:0] mci, np, hdata;
    @(negedge clk);
    check_outputs();
    mcv = 0;
    if (r && m_wait) begin
      if (mc_delay == 0) mcv = 1;
      else mc_delay--;
    end
    mci = mcv ? mem_word(m_req) : $urandom;
    rdy = r; IQ_is_full = f; PDC_need_jump = j; PDC_predicted_imm = imm;
    ROB_roll_back_flag = rb; ROB_roll_back_pc = rbpc;
    MC_input_valid = mcv; MC_inst = mci;
    #1;
    h = cached(m_pc);
    hdata = c_data[slot(m_pc)];
    check("pdc_pc", PDC_inst_pc, m_pc);
    check("pdc_inst", PDC_inst, h ? hdata : mci);
    if (!r) return;
    np = j ? m_pc + imm : m_pc + 32'd4;
    m_ov = 0;
    if (!m_wait) begin
      if (rb) m_pc = rbpc;
      else if (!f) begin
        if (h) deliver(hdata, j, np);
        else begin
          m_wait = 1; m_drop = 0; m_req = m_pc;
          mc_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
      end
    end else begin
      if (mcv) begin
        c_valid[slot(m_req)] = 1; c_addr[slot(m_req)] = m_req; c_data[slot(m_req)] = mci;
        m_wait = 0;
        if (!m_drop && !rb && !f) deliver(mci, j, np);
      end else if (rb) m_drop = 1;
      if (rb) m_pc = rbpc;
    end
  endtask

  task automatic rand_step();
    int k;
    k = int'($urandom_range(0, 32));
    step(($urandom % 10) != 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
         32'((k - 16) * 4), ($urandom % 20) == 0, 32'($urandom_range(0, 63) * 4));
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Cold start at pc 0 with a fixed MC latency.
    fixed_delay = 2; obs_need = 0; obs_pulse = 0;
    repeat (4) step(1, 0, 0, '0, 0, '0);
    repeat (2) step(1, 1, 0, '0, 0, '0);
    check("t1_need_cycles", obs_need, 32'd3);
    check("t1_pulses", obs_pulse, 32'd1);
    fixed_delay = -1;

    // Short loop 0x0..0x8 with a taken branch back to 0 at 0x8.
    repeat (40) begin
      step(1, 0, m_pc == 32'h8, 32'hFFFF_FFF8, m_pc > 32'h8, 32'h0);
    end

    repeat (3000) rand_step();

    // Asynchronous reset while a miss is outstanding.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1, 0, 0, '0, 0, '0);
      found = m_wait;
    end
    check("wait_reached", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    rdy = 1'b0; MC_input_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_pdc_pc", PDC_inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    repeat (1500) rand_step();
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
